fb_arbiter: RTL

Framebuffer memory scheduler between the 640x480 display timing generator and the Mandelbrot renderer. It owns the single-port framebuffer RAM and, on each `line` pulse, fetches the next display line into a ping-pong line buffer with absolute priority. In the remaining cycles it grants renderer pixel writes. It also manages front/back buffer swaps at frame boundaries.

---
 rtl/fb_pkg.sv | 15 +
 rtl/fb_rd_pipe.sv | 36 +++
 rtl/fb_arbiter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared state type and buffer base address helper for fb_arbiter
package fb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fb_state_t;

    // Buffers are whole frames laid out back to back, so buffer 1 starts one frame in.
    function automatic int base_addr(input logic buf_sel, input int line_len, input int v_res);
        return buf_sel ? line_len * v_res : 0;
    endfunction

endpackage

// File: rtl/fb_rd_pipe.sv
// rtl/fb_rd_pipe.sv - LAT-deep delay line carrying {valid, bank, idx} alongside RAM read latency
module fb_rd_pipe #(
    parameter int LAT  = 2,
    parameter int IDXW = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rd_valid,
    input  logic            rd_bank,
    input  logic [IDXW-1:0] rd_idx,
    output logic            ret_valid,
    output logic            ret_bank,
    output logic [IDXW-1:0] ret_idx
);

    logic [LAT-1:0]         valid_sr;
    logic [LAT-1:0][IDXW:0] tag_sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_sr <= '0;
            tag_sr   <= '0;
        end else begin
            valid_sr[0] <= rd_valid;
            tag_sr[0]   <= {rd_bank, rd_idx};
            for (int i = 1; i < LAT; i++) begin
                valid_sr[i] <= valid_sr[i-1];
                tag_sr[i]   <= tag_sr[i-1];
            end
        end
    end

    assign ret_valid           = valid_sr[LAT-1];
    assign {ret_bank, ret_idx} = tag_sr[LAT-1];

endmodule

// File: rtl/fb_arbiter.sv
// rtl/fb_arbiter.sv - framebuffer port scheduler: line fetch priority, renderer writes, buffer swap
// FB_DOUBLE_BUF_EN selects front/back double buffering; undefined gives a single buffer at 0.
module fb_arbiter
    import fb_pkg::*;
#(
    parameter int CORDW    = 16,
    parameter int V_RES    = 480,
    parameter int LINE_LEN = 640,
    parameter int ADDRW    = 20,
    parameter int DATAW    = 4,
    parameter int LAT      = 2
) (
    input  logic                           clk_pix,
    input  logic                           rst_pix_n,
    input  logic                           frame,
    input  logic                           line,
    input  logic signed [CORDW-1:0]        sy,
    input  logic                           wr_req,
    input  logic [ADDRW-1:0]               wr_addr,
    input  logic [DATAW-1:0]               wr_data,
    output logic                           wr_ack,
    input  logic                           swap_req,
    output logic                           swap_done,
    output logic                           mem_en,
    output logic                           mem_we,
    output logic [ADDRW-1:0]               mem_addr,
    output logic [DATAW-1:0]               mem_wdata,
    input  logic [DATAW-1:0]               mem_rdata,
    output logic                           lb_we,
    output logic [$clog2(LINE_LEN):0]      lb_addr,
    output logic [DATAW-1:0]               lb_data,
    output logic                           underrun
);

    localparam int IDXW = $clog2(LINE_LEN);
    localparam int CNTW = $clog2(LAT + 1);

    fb_state_t        state;
    logic [IDXW-1:0]  idx;
    logic [CNTW-1:0]  drain_cnt;
    logic [ADDRW-1:0] fetch_ptr;
    logic             cur_bank;
    logic             rd_bank;
    logic [IDXW-1:0]  rd_idx;
    logic             trigger;
    logic [ADDRW-1:0] new_front_base;
    logic [ADDRW-1:0] back_base;
    logic [ADDRW-1:0] ptr_now;
    logic             ret_valid;
    logic             ret_bank;
    logic [IDXW-1:0]  ret_idx;

    // Line -1 prefetches line 0; the last visible line has nothing after it to fetch.
    assign trigger = line && ((sy == '1) || (!sy[CORDW-1] && (sy < CORDW'(V_RES - 1))));

`ifdef FB_DOUBLE_BUF_EN
    logic front;
    logic pending;
    logic swap_now;

    assign swap_now       = frame && (pending || swap_req);
    assign new_front_base = ADDRW'(base_addr(front ^ swap_now, LINE_LEN, V_RES));
    assign back_base      = ADDRW'(base_addr(!front, LINE_LEN, V_RES));

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            front     <= 1'b0;
            pending   <= 1'b0;
            swap_done <= 1'b0;
        end else begin
            swap_done <= swap_now;
            if (swap_now) begin
                front   <= ~front;
                pending <= 1'b0;
            end else if (swap_req) begin
                pending <= 1'b1;
            end
        end
    end
`else
    logic unused_swap;

    assign unused_swap    = swap_req;
    assign new_front_base = '0;
    assign back_base      = '0;
    assign swap_done      = 1'b0;
`endif

    // A frame pulse coinciding with a trigger must already fetch from the new front buffer.
    assign ptr_now = frame ? new_front_base : fetch_ptr;
    assign wr_ack  = rst_pix_n && wr_req && (state == IDLE) && !trigger;

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            state     <= IDLE;
            idx       <= '0;
            drain_cnt <= '0;
            fetch_ptr <= '0;
            cur_bank  <= 1'b0;
            rd_bank   <= 1'b0;
            rd_idx    <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            underrun  <= 1'b0;
        end else begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            fetch_ptr <= ptr_now;
            if (trigger) begin
                if (state != IDLE) underrun <= 1'b1;
                state     <= FETCH;
                cur_bank  <= ~cur_bank;
                rd_bank   <= ~cur_bank;
                rd_idx    <= '0;
                idx       <= IDXW'(1);
                mem_en    <= 1'b1;
                mem_addr  <= ptr_now;
                fetch_ptr <= ptr_now + ADDRW'(1);
            end else begin
                case (state)
                    IDLE: begin
                        if (wr_ack) begin
                            mem_en    <= 1'b1;
                            mem_we    <= 1'b1;
                            mem_addr  <= back_base + wr_addr;
                            mem_wdata <= wr_data;
                        end
                    end
                    FETCH: begin
                        mem_en    <= 1'b1;
                        mem_addr  <= ptr_now;
                        fetch_ptr <= ptr_now + ADDRW'(1);
                        rd_idx    <= idx;
                        idx       <= idx + IDXW'(1);
                        if (idx == IDXW'(LINE_LEN - 1)) begin
                            state     <= DRAIN;
                            drain_cnt <= '0;
                        end
                    end
                    DRAIN: begin
                        if (drain_cnt == CNTW'(LAT)) state <= IDLE;
                        else drain_cnt <= drain_cnt + CNTW'(1);
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    fb_rd_pipe #(
        .LAT  (LAT),
        .IDXW (IDXW)
    ) u_rd_pipe (
        .clk       (clk_pix),
        .rst_n     (rst_pix_n),
        .rd_valid  (mem_en && !mem_we),
        .rd_bank   (rd_bank),
        .rd_idx    (rd_idx),
        .ret_valid (ret_valid),
        .ret_bank  (ret_bank),
        .ret_idx   (ret_idx)
    );

    assign lb_we   = ret_valid;
    assign lb_addr = {ret_bank, ret_idx};
    assign lb_data = ret_valid ? mem_rdata : '0;

endmodule
